pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised elastic pipeline stage register. Generalises the fixed MEM/WB latch: carries
//  arbitrary control/data bundles with valid/ready handshake, 2-entry skid buffer, flush
//  (bubble insertion) and a stall-cycle counter. Sits between any two CPU pipeline stages.
//  Allows back-pressure without a combinational ready path.
// PARAMETERS
//  DATA_W    32  width of the data bundle (ALU out, read data, PC+4, instruction, ...)
//  CTRL_W    4   width of the control bundle (regwrite, memtoreg, regin[1:0], ...)
//  CNT_W     16  width of the saturating stall counter
// PORTS
//  clk        in   1       rising-edge clock (the only clock)
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat; registered output
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  flush      in   1       kill all held beats and the incoming beat this cycle
//  out_valid  out  1       beat held at output
//  out_ready  in   1       downstream accepts beat
//  out_ctrl   out  CTRL_W  control bundle; forced to 0 whenever out_valid=0
//  out_data   out  DATA_W  data bundle; don't-care when out_valid=0
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at posedge): state EMPTY, out_valid=0, out_ctrl=0, out_data=0,
//   in_ready=1, stall_cnt=0. Skid regs cleared. rst overrides flush and all handshakes.
//  Transfer rules: in-xfer = in_valid&in_ready; out-xfer = out_valid&out_ready.
//  Latency: 1 cycle. A beat accepted at edge N is on out_* after edge N.
//  States (2-bit, main reg M, skid reg S):
//   EMPTY: in-xfer -> load M, go ONE.
//   ONE:  in-xfer & out-xfer -> M<=in, stay ONE.
//         in-xfer only -> S<=in, go TWO (in_ready drops next cycle).
//         out-xfer only -> go EMPTY.
//   TWO:  in_ready=0. out-xfer -> M<=S, go ONE. Otherwise hold.
//  in_ready = (state != TWO). It is a register, not a function of out_ready.
//  Order: beats leave in acceptance order. No duplication or loss except by flush.
//  flush=1 (rst=0): next state EMPTY. M.ctrl and S.ctrl are cleared, so a bubble is
//   inserted. Any in-xfer in the same cycle is discarded. A simultaneous out-xfer
//   completes normally this cycle. Data regs may keep stale values.
//  out_ctrl gating: out_ctrl = out_valid ? M.ctrl : 0. A bubble never asserts regwrite.
//  stall_cnt: +1 on each cycle with out_valid & !out_ready. Holds at 2^CNT_W-1.
//   Cleared only by rst; flush does not clear it.
//  Data width: bundles pass bit-exact; no arithmetic on payload.
//  Illegal state encoding (3): recovers to EMPTY on the next edge.
// STRUCTURE
//  Shared package pipe_pkg: localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
//   Same encoding is reused by the other pipe_* stages.
//  One natural sub-module: pipe_slot (CTRL_W+DATA_W load-enable register with sync clear
//   of ctrl). Instantiated twice (M, S). The FSM and counter stay in the top module.
//  MEM/WB instance: CTRL_W=4 {regwrite,memtoreg,regin}, DATA_W=5*32 {ALUout,drdata,
//   immgen,PC+4,idata}; daddr is carried in a second instance or appended to data.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1,
//    stall_cnt=0.
//  2 Streaming: out_ready=1, beats 0x11..0x18 on consecutive cycles -> same values on
//    out_data one cycle later, in_ready stays 1, stall_cnt=0.
//  3 Back-pressure: send 0xA1,0xA2,0xA3 with out_ready=0 -> 0xA1 held, 0xA2 in skid,
//    in_ready=0 after 2nd accept, 0xA3 not accepted. Raise out_ready -> A1,A2,A3 in order.
//    stall_cnt equals the low cycles.
//  4 Flush in TWO with in_valid=1 (0xB3) -> next cycle out_valid=0, out_ctrl=0,
//    in_ready=1. 0xB3 never appears at the output.
//  5 Flush with simultaneous out-xfer of 0xC1 -> 0xC1 is consumed once. A flush and
//    rst in the same cycle give the reset values.
//  6 Saturation: CNT_W=4, out_ready=0 for 20 cycles with a valid beat -> stall_cnt=15
//    and holds. Release -> the beat transfers and stall_cnt stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_* elastic stage family: occupancy state encoding
// and a small helper that turns an occupancy state into the registered ready flag.
package pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_ONE   = 2'd1;
    localparam pipe_state_t ST_TWO   = 2'd2;

    function automatic logic state_can_accept(input pipe_state_t st);
        return (st != ST_TWO);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One beat holding register: load-enabled ctrl+data with a synchronous ctrl clear
// so a flushed slot always reads back as a bubble.
module pipe_slot #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else begin
            if (clr_ctrl)
                q_ctrl <= '0;
            else if (load)
                q_ctrl <= d_ctrl;
            if (load)
                q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer, flush-to-bubble and a
// saturating stall counter; ready toward upstream is a pure register.
//
//  state    | meaning
//  ST_EMPTY | nothing held, out_valid=0, in_ready=1
//  ST_ONE   | beat in main slot M, in_ready=1
//  ST_TWO   | M holds the oldest beat, skid slot S the next one, in_ready=0
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_t       state, state_nxt;
    logic              in_xfer, out_xfer;
    logic              m_load, s_load, m_from_skid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
    logic [DATA_W-1:0] m_data, s_data, m_d_data;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_nxt   = state;
        m_load      = 1'b0;
        s_load      = 1'b0;
        m_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    m_load    = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    m_load = 1'b1;
                end else if (in_xfer) begin
                    s_load    = 1'b1;
                    state_nxt = ST_TWO;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    state_nxt   = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush discards everything held plus any beat arriving this cycle.
        if (flush) begin
            state_nxt = ST_EMPTY;
            m_load    = 1'b0;
            s_load    = 1'b0;
        end
    end

    assign m_d_ctrl = m_from_skid ? s_ctrl : in_ctrl;
    assign m_d_data = m_from_skid ? s_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot_m (
        .clk      (clk),
        .rst      (rst),
        .load     (m_load),
        .clr_ctrl (flush),
        .d_ctrl   (m_d_ctrl),
        .d_data   (m_d_data),
        .q_ctrl   (m_ctrl),
        .q_data   (m_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot_s (
        .clk      (clk),
        .rst      (rst),
        .load     (s_load),
        .clr_ctrl (flush),
        .d_ctrl   (in_ctrl),
        .d_data   (in_data),
        .q_ctrl   (s_ctrl),
        .q_data   (s_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= state_can_accept(state_nxt);
            out_valid <= (state_nxt == ST_ONE) || (state_nxt == ST_TWO);
            if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_ctrl = out_valid ? m_ctrl : '0;
    assign out_data = m_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int CNT_SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t mq[$];
    beat_t out_log[$];
    int    m_cnt  = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit ix, ox;
        @(posedge clk);
        ix = in_valid && (mq.size() < 2);
        ox = (mq.size() > 0) && out_ready;
        if (rst) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && m_cnt < CNT_SAT) m_cnt++;
            if (ox) out_log.push_back(mq[0]);
            if (flush) mq.delete();
            else begin
                if (ox) void'(mq.pop_front());
                if (ix) mq.push_back({in_ctrl, in_data});
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_ctrl", 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'(0));
        if (mq.size() > 0) chk("out_data", 64'(out_data), 64'(mq[0].d));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        out_log.delete();
    endtask

    int n;

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // 1: reset with a valid beat offered
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        rst = 1'b0;
        out_log.delete();

        // 2: streaming
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, CW'(i), DW'(32'h11 + i), 1'b1, 1'b0);
            step();
            chk("stream_data", 64'(out_data), 64'(32'h11 + i));
            chk("stream_ready", 64'(in_ready), 64'(1));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        chk("stream_stall", 64'(stall_cnt), 64'(0));
        chk("stream_count", 64'(out_log.size()), 64'(8));

        // 3: back-pressure, skid fill, ordered drain
        do_reset();
        drive(1'b1, 4'h1, 32'hA1, 1'b0, 1'b0); step();
        drive(1'b1, 4'h2, 32'hA2, 1'b0, 1'b0); step();
        chk("bp_ready_low", 64'(in_ready), 64'(0));
        drive(1'b1, 4'h3, 32'hA3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("bp_held", 64'(out_data), 64'(32'hA1));
        chk("bp_stall", 64'(stall_cnt), 64'(4));
        drive(1'b1, 4'h3, 32'hA3, 1'b1, 1'b0); step(); step();
        drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();
        chk("bp_order_n", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) begin
            chk("bp_order0", 64'(out_log[0].d), 64'(32'hA1));
            chk("bp_order1", 64'(out_log[1].d), 64'(32'hA2));
            chk("bp_order2", 64'(out_log[2].d), 64'(32'hA3));
        end

        // 4: flush while full with an incoming beat
        do_reset();
        drive(1'b1, 4'hF, 32'hB1, 1'b0, 1'b0); step();
        drive(1'b1, 4'hF, 32'hB2, 1'b0, 1'b0); step();
        drive(1'b1, 4'hF, 32'hB3, 1'b0, 1'b1); step();
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_ctrl", 64'(out_ctrl), 64'(0));
        chk("fl_ready", 64'(in_ready), 64'(1));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        n = 0;
        foreach (out_log[i]) if (out_log[i].d == 32'hB3) n++;
        chk("fl_no_b3", 64'(n), 64'(0));

        // 5: flush with simultaneous out-xfer, then flush+rst together
        do_reset();
        drive(1'b1, 4'h5, 32'hC1, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, 1'b1, 1'b1); step();
        drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();
        n = 0;
        foreach (out_log[i]) if (out_log[i].d == 32'hC1) n++;
        chk("c1_once", 64'(n), 64'(1));
        drive(1'b1, 4'h7, 32'hC2, 1'b0, 1'b0); step(); step();
        rst = 1'b1;
        drive(1'b1, 4'h7, 32'hC3, 1'b0, 1'b1); step();
        rst = 1'b0;
        chk("rf_valid", 64'(out_valid), 64'(0));
        chk("rf_ready", 64'(in_ready), 64'(1));
        chk("rf_stall", 64'(stall_cnt), 64'(0));

        // 6: stall counter saturation
        do_reset();
        drive(1'b1, 4'h9, 32'hD1, 1'b0, 1'b0); step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", 64'(stall_cnt), 64'(CNT_SAT));
        drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();
        chk("sat_hold", 64'(stall_cnt), 64'(CNT_SAT));
        chk("sat_xfer", (out_log.size() == 1) ? 64'(out_log[0].d) : 64'(0), 64'(32'hD1));

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 3) != 0), CW'($urandom), DW'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
